// File: rtl/ad100_mem_arbiter_pkg.sv
// Shared types and helpers for the ad100 fetch/data RAM arbiter.
package ad100_mem_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 30;
    localparam int BE_W   = 4;

    // State names what the arbiter issued to the RAM in the previous cycle
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF_RD = 3'd1,
        ST_D_RD  = 3'd2,
        ST_D_WR  = 3'd3,
        ST_D_RMW = 3'd4
    } arb_state_t;

    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [BE_W-1:0]   be,
        input logic [WORD_W-1:0] wdata,
        input logic [WORD_W-1:0] rdata
    );
        logic [WORD_W-1:0] merged;
        merged = rdata;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ad100_mem_arb_pick.sv
// Fetch/data grant selection with a starvation counter that lets fetch
// win once it has been refused STARVE_LIMIT consecutive cycles.
module ad100_mem_arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    input  logic allow,
    output logic if_gnt,
    output logic d_gnt
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_fetch_wins;

    assign w_fetch_wins = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    assign if_gnt       = allow & if_req & (~d_req | w_fetch_wins);
    assign d_gnt        = allow & d_req & ~(if_req & w_fetch_wins);

    // Counts refused fetch cycles, including cycles where nobody may be granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            r_starve_cnt <= '0;
        end else if (!w_fetch_wins) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ad100_mem_arbiter.sv
// Shares one single-port word RAM between the ad100 fetch and data ports,
// with read-modify-write for partial stores.
module ad100_mem_arbiter
    import ad100_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [WORD_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_we,
    input  logic [BE_W-1:0]     d_be,
    input  logic [WORD_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORD_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata
);

    arb_state_t          r_state;
    logic [ADDR_W-1:0]   r_rmw_addr;
    logic [BE_W-1:0]     r_rmw_be;
    logic [WORD_W-1:0]   r_rmw_wdata;
    logic                w_allow;

    // Reset also masks grants so every output is quiet while rst_n is low
    assign w_allow = rst_n & (r_state != ST_D_RMW);

    ad100_mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .allow  (w_allow),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    assign if_rvalid = (r_state == ST_IF_RD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rvalid  = (r_state == ST_D_RD) || (r_state == ST_D_WR);
    assign d_rdata   = (r_state == ST_D_RD) ? mem_rdata : '0;

    // RAM port: finish a pending RMW first, otherwise serve the granted requester
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == ST_D_RMW) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_rmw_addr;
            mem_wdata = merge_bytes(r_rmw_be, r_rmw_wdata, mem_rdata);
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (d_gnt) begin
            if (!d_we || (d_be != '0)) begin
                mem_en   = 1'b1;
                mem_addr = d_addr;
            end
            if (d_we && (&d_be)) begin
                mem_we    = 1'b1;
                mem_wdata = d_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rmw_addr  <= '0;
            r_rmw_be    <= '0;
            r_rmw_wdata <= '0;
        end else if (r_state == ST_D_RMW) begin
            r_state <= ST_D_WR;
        end else if (if_gnt) begin
            r_state <= ST_IF_RD;
        end else if (d_gnt) begin
            if (!d_we) begin
                r_state <= ST_D_RD;
            end else if ((&d_be) || (d_be == '0)) begin
                r_state <= ST_D_WR;
            end else begin
                r_state     <= ST_D_RMW;
                r_rmw_addr  <= d_addr;
                r_rmw_be    <= d_be;
                r_rmw_wdata <= d_wdata;
            end
        end else begin
            r_state <= ST_IDLE;
        end
    end

endmodule
